// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data requesters. It grants one fixed-latency
// access at a time. Data has priority, but fetch is served after a bounded run of data grants.
module mem_arbiter #(
   parameter int WIDTH           = 32,
   parameter int MEM_LATENCY     = 2,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [WIDTH-1:0] if_addr,
   output logic [WIDTH-1:0] if_rdata,
   output logic             if_valid,
   output logic             if_stall,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_valid,
   output logic             d_stall,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [2:0] LAT_M1     = 3'(MEM_LATENCY - 1);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   state_t     state, state_nxt;
   logic       owner_d, owner_d_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [3:0] streak, streak_nxt;
   logic       grant, grant_d, resp;
   logic       sel_d, active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         owner_d <= 1'b1;
         cnt     <= '0;
         streak  <= '0;
      end else begin
         state   <= state_nxt;
         owner_d <= owner_d_nxt;
         cnt     <= cnt_nxt;
         streak  <= streak_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      owner_d_nxt = owner_d;
      cnt_nxt     = cnt;
      streak_nxt  = streak;
      grant       = 1'b0;
      grant_d     = 1'b0;
      resp        = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               grant       = 1'b1;
               grant_d     = d_req && (!if_req || streak != STREAK_MAX);
               owner_d_nxt = grant_d;
               cnt_nxt     = LAT_M1;
               state_nxt   = WAIT;
               // The streak counts only data grants that made a waiting fetch lose.
               if (grant_d && if_req)
                  streak_nxt = (streak >= STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
               else
                  streak_nxt = '0;
            end
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               resp      = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sel_d  = (state == IDLE) ? grant_d : owner_d;
   assign active = grant || (state == WAIT);

   // Everything is forced low while rst is high. An IDLE state with live requests
   // would otherwise grant combinationally during reset.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_valid  = 1'b0;
      if_rdata  = '0;
      if_stall  = 1'b0;
      d_valid   = 1'b0;
      d_rdata   = '0;
      d_stall   = 1'b0;
      if (!rst) begin
         mem_en = grant;
         if (active) begin
            mem_we    = sel_d && d_we;
            mem_addr  = sel_d ? d_addr : if_addr;
            mem_wdata = (sel_d && d_we) ? d_wdata : '0;
         end
         if_valid = resp && !owner_d;
         d_valid  = resp && owner_d;
         if (if_valid)           if_rdata = mem_rdata;
         if (d_valid && !d_we)   d_rdata  = mem_rdata;
         if_stall = if_req && !if_valid;
         d_stall  = d_req && !d_valid;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LATENCY=2, MAX_DATA_STREAK=4): per-cycle vector table
// plus hand-written starvation and mid-transaction reset sequences.
module tb_mem_arbiter;

   localparam logic [31:0] IA = 32'h0000_0100;
   localparam logic [31:0] DA = 32'h0000_0200;
   localparam logic [31:0] WD = 32'h1234_5678;
   localparam logic [31:0] M  = 32'hFFFF_0000;
   localparam logic [31:0] R  = 32'hDEAD_BEEF;
   localparam logic [31:0] A1 = 32'hAAAA_0001;
   localparam logic [31:0] A2 = 32'h0000_0055;

   logic        clk = 1'b0, rst = 1'b1;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = IA, d_addr = DA, d_wdata = WD, mem_rdata = M;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_en, mem_we;

   int n_chk = 0, n_fail = 0;

   mem_arbiter #(.WIDTH(32), .MEM_LATENCY(2), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .d_valid(d_valid), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ifq, dq, we_in;
      logic [31:0] mrd;
      logic        en, we;
      logic [31:0] addr, wdata;
      logic        ifv;
      logic [31:0] ifr;
      logic        ifs, dv;
      logic [31:0] dr;
      logic        ds;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, ifq, dq, wi, input logic [31:0] mrd,
                      input logic en, we, input logic [31:0] addr, wdata,
                      input logic ifv, input logic [31:0] ifr, input logic ifs,
                      input logic dv, input logic [31:0] dr, input logic ds);
      vec_t v;
      v.rst = r; v.ifq = ifq; v.dq = dq; v.we_in = wi; v.mrd = mrd;
      v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
      v.ifv = ifv; v.ifr = ifr; v.ifs = ifs; v.dv = dv; v.dr = dr; v.ds = ds;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   initial begin
      // reset with both requests high
      add(1,1,1,0,M,  0,0,0 ,0 , 0,0,0, 0,0 ,0);
      add(1,1,1,0,M,  0,0,0 ,0 , 0,0,0, 0,0 ,0);
      // contention: D first, then F
      add(0,1,1,0,M,  1,0,DA,0 , 0,0,1, 0,0 ,1);
      add(0,1,1,0,M,  0,0,DA,0 , 0,0,1, 0,0 ,1);
      add(0,1,1,0,A1, 0,0,DA,0 , 0,0,1, 1,A1,0);
      add(0,1,0,0,M,  1,0,IA,0 , 0,0,1, 0,0 ,0);
      add(0,1,0,0,M,  0,0,IA,0 , 0,0,1, 0,0 ,0);
      add(0,1,0,0,R,  0,0,IA,0 , 1,R,0, 0,0 ,0);
      add(0,0,0,0,A1, 0,0,0 ,0 , 0,0,0, 0,0 ,0);
      // fetch only
      add(0,1,0,0,M,  1,0,IA,0 , 0,0,1, 0,0 ,0);
      add(0,1,0,0,M,  0,0,IA,0 , 0,0,1, 0,0 ,0);
      add(0,1,0,0,R,  0,0,IA,0 , 1,R,0, 0,0 ,0);
      add(0,0,0,0,M,  0,0,0 ,0 , 0,0,0, 0,0 ,0);
      // store
      add(0,0,1,1,M,  1,1,DA,WD, 0,0,0, 0,0 ,1);
      add(0,0,1,1,M,  0,1,DA,WD, 0,0,0, 0,0 ,1);
      add(0,0,1,1,A2, 0,1,DA,WD, 0,0,0, 1,0 ,0);
      add(0,0,0,0,M,  0,0,0 ,0 , 0,0,0, 0,0 ,0);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; if_req = tbl[i].ifq; d_req = tbl[i].dq;
         d_we = tbl[i].we_in; mem_rdata = tbl[i].mrd;
         #1;
         chk("mem_en",    {31'd0, mem_en},   {31'd0, tbl[i].en});
         chk("mem_we",    {31'd0, mem_we},   {31'd0, tbl[i].we});
         chk("mem_addr",  mem_addr,          tbl[i].addr);
         chk("mem_wdata", mem_wdata,         tbl[i].wdata);
         chk("if_valid",  {31'd0, if_valid}, {31'd0, tbl[i].ifv});
         chk("if_rdata",  if_rdata,          tbl[i].ifr);
         chk("if_stall",  {31'd0, if_stall}, {31'd0, tbl[i].ifs});
         chk("d_valid",   {31'd0, d_valid},  {31'd0, tbl[i].dv});
         chk("d_rdata",   d_rdata,           tbl[i].dr);
         chk("d_stall",   {31'd0, d_stall},  {31'd0, tbl[i].ds});
      end

      // starvation: both held, grants at c0,3,6,9 go to D, c12 to F, c15 to D
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      for (int c = 0; c < 18; c++) begin
         if (c > 0) @(negedge clk);
         mem_rdata = (c % 3 == 2) ? 32'hC0DE_0000 + 32'(c) : M;
         #1;
         chk("starve_en", {31'd0, mem_en}, {31'd0, (c % 3 == 0)});
         if (c % 3 == 0) chk("starve_addr", mem_addr, (c == 12) ? IA : DA);
         chk("starve_ifv", {31'd0, if_valid}, {31'd0, (c == 14)});
         chk("starve_dv",  {31'd0, d_valid},  {31'd0, (c % 3 == 2 && c != 14)});
         if (c == 14) chk("starve_ifr", if_rdata, 32'hC0DE_000E);
         if (c == 11) chk("starve_dr",  d_rdata,  32'hC0DE_000B);
      end
      @(negedge clk);
      if_req = 1'b0; d_req = 1'b0; mem_rdata = M;
      #1 chk("starve_idle_en", {31'd0, mem_en}, 32'd0);

      // reset while a fetch is in flight
      @(negedge clk);
      if_req = 1'b1;
      #1 chk("rmid_c0_en", {31'd0, mem_en}, 32'd1);
      chk("rmid_c0_addr", mem_addr, IA);
      @(negedge clk);
      rst = 1'b1;
      #1 chk("rmid_c1_en", {31'd0, mem_en}, 32'd0);
      chk("rmid_c1_stall", {31'd0, if_stall}, 32'd0);
      chk("rmid_c1_addr", mem_addr, 32'd0);
      @(negedge clk);
      mem_rdata = R;
      #1 chk("rmid_c2_ifv", {31'd0, if_valid}, 32'd0);
      chk("rmid_c2_en", {31'd0, mem_en}, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_rdata = M;
      #1 chk("rmid_c3_en", {31'd0, mem_en}, 32'd1);
      chk("rmid_c3_addr", mem_addr, IA);
      chk("rmid_c3_stall", {31'd0, if_stall}, 32'd1);
      @(negedge clk);
      #1 chk("rmid_c4_ifv", {31'd0, if_valid}, 32'd0);
      chk("rmid_c4_stall", {31'd0, if_stall}, 32'd1);
      @(negedge clk);
      mem_rdata = 32'h0BAD_F00D;
      #1 chk("rmid_c5_ifv", {31'd0, if_valid}, 32'd1);
      chk("rmid_c5_ifr", if_rdata, 32'h0BAD_F00D);
      chk("rmid_c5_stall", {31'd0, if_stall}, 32'd0);
      @(negedge clk);
      if_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer for the RV32I core: shares one unified, fixed-latency synchronous memory between the fetch stage (instruction reads) and the memory stage (loads/stores). Grants one transaction at a time, counts out memory latency, returns a one-cycle response pulse to the owner, and drives per-requester stall flags into the hazard logic. Data requests have priority, with a bounded-streak rule so fetch cannot starve.

## Interface
- WIDTH, 32, data and address width
- MEM_LATENCY, 2, cycles from grant (mem_en) to valid mem_rdata; legal 1..7
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits; legal 1..15

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request, held until if_valid
- if_addr  in  WIDTH  fetch address, stable while if_req
- if_rdata  out  WIDTH  fetch read data, valid with if_valid, else 0
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  fetch waiting: if_req & ~if_valid
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  WIDTH  data address, stable while d_req
- d_wdata  in  WIDTH  store data, stable while d_req
- d_rdata  out  WIDTH  load data, valid with d_valid on loads, else 0
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- d_stall  out  1  data waiting: d_req & ~d_valid
- mem_en  out  1  memory access strobe, high only in grant cycle
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  WIDTH  owner's address during whole transaction, else 0
- mem_wdata  out  WIDTH  owner's write data (data owner, store), else 0
- mem_rdata  in  WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

## Operation
- FSM states: IDLE, WAIT. Registers: owner (F/D), latency counter (3 bits), streak counter (4 bits).
- IDLE: if any req, grant combinationally same cycle: mem_en=1, owner latched, counter loaded MEM_LATENCY-1, go WAIT. No req: stay IDLE, mem_en=0.
- Grant selection: d_req only -> D; if_req only -> F; both -> D unless streak == MAX_DATA_STREAK, then F.
- Streak: F grant -> 0; D grant with if_req high -> +1, saturating at MAX_DATA_STREAK; D grant with if_req low -> 0.
- WAIT: counter decrements each cycle; counter 0 is the response cycle: owner's valid=1, rdata=mem_rdata (d_rdata=0 for stores), next state IDLE.
- No new grant in the response cycle; a req still high in the following IDLE cycle is a new transaction.
- mem_addr/mem_we/mem_wdata track owner inputs from grant through response; 0 in IDLE without grant.
- Requester changing addr/data mid-transaction or dropping req before valid: outside protocol; arbiter still completes and pulses valid.

## Timing
- Grant at cycle t -> valid at t+MEM_LATENCY -> next grant earliest t+MEM_LATENCY+1. Throughput one access per MEM_LATENCY+1 cycles.
- Valid, rdata, stall outputs are combinational from state and inputs; no registered output delay.
- Reset (async, any state, any cycle): state IDLE, counter 0, streak 0, owner D; while rst high all outputs 0 (including mem_en, stalls). In-flight transaction abandoned, no valid pulse. First grant possible in first cycle with rst low.
- Simultaneous req arrival in IDLE resolved by priority rule in the same cycle; loser's stall stays high.

## Test plan
- Reset: rst=1 with if_req=d_req=1 -> mem_en, valids, stalls all 0; first cycle after release grants D (mem_addr=d_addr).
- Fetch only, MEM_LATENCY=2: if_req at c0, if_addr=0x100, mem_rdata=0xDEADBEEF at c2 -> mem_en c0 only, mem_addr=0x100 c0-c2, if_stall c0-c1, if_valid c2 with if_rdata=0xDEADBEEF, if_stall 0 at c2.
- Contention: both req at c0 -> D granted c0, d_valid c2; F granted c3, if_valid c5; if_stall high c0-c4.
- Starvation, MAX_DATA_STREAK=4, both req held continuously -> grant order D,D,D,D,F at c0,c3,c6,c9,c12; then D at c15.
- Store: d_we=1, d_addr=0x200, d_wdata=0x12345678 at c0 -> mem_en=mem_we=1 c0, mem_wdata=0x12345678, d_valid c2 with d_rdata=0.
- Reset mid-transaction: fetch granted c0, rst pulse at c1 -> if_valid never asserted for it; rst low at c3 with if_req high -> new grant c3, if_valid c5.
